tick_blinker: RTL and testbench

Output-side counterpart to the push-button input chain: the input chain turns a human-speed press into a single-cycle `tick`, and this block turns single-cycle `tick` events back into human-visible LED blinks. Each `tick` produces exactly one blink: `led` stays on for ON_TICKS slow periods, then off for OFF_TICKS slow periods. A saturating pending counter queues ticks that arrive while a blink is in progress. The block sits between any tick producer (e.g. a debounced button edge) and a board LED pin.

---
 rtl/tick_blinker_if.sv | 27 ++
 rtl/tick_blinker.sv | 140 ++++++++++++++
 tb/tb_tick_blinker.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/tick_blinker_if.sv
// Bundle of the tick input and the blink/status outputs of tick_blinker.
// master drives tick (producer side); slave is the blinker itself.
interface tick_blinker_if #(
    parameter int unsigned CNT_W = 4
) ();
    logic             tick;
    logic             led;
    logic             busy;
    logic [CNT_W-1:0] pending;
    logic             ovf;

    modport master (
        output tick,
        input  led,
        input  busy,
        input  pending,
        input  ovf
    );

    modport slave (
        input  tick,
        output led,
        output busy,
        output pending,
        output ovf
    );
endinterface

// File: rtl/tick_blinker.sv
// Turns single-cycle tick events into LED blinks (ON_TICKS on, OFF_TICKS off, in DIV-cycle units),
// queueing ticks in a saturating counter. Define TICK_BLINKER_OVF_EN for the sticky ovf flag.
module tick_blinker #(
    parameter int unsigned DIV       = 500000,
    parameter int unsigned ON_TICKS  = 25,
    parameter int unsigned OFF_TICKS = 25,
    parameter int unsigned CNT_W     = 4
) (
    input logic           clk,
    input logic           rst,
    tick_blinker_if.slave io_blk
);

    typedef enum logic [1:0] {
        StIdle,
        StOn,
        StOff
    } state_e;

    localparam logic [31:0] DivLast = 32'(DIV - 1);
    localparam logic [15:0] OnLast  = 16'(ON_TICKS - 1);
    localparam logic [15:0] OffLast = 16'(OFF_TICKS - 1);

    state_e           r_state;
    state_e           w_state_d;
    logic [31:0]      r_presc;
    logic [31:0]      w_presc_d;
    logic [15:0]      r_phase;
    logic [15:0]      w_phase_d;
    logic [CNT_W-1:0] r_pending;
    logic [CNT_W-1:0] w_pending_d;

    logic w_strobe;
    logic w_on_done;
    logic w_off_done;
    logic w_deq;
    logic w_full;
    logic w_trans;

    assign w_strobe   = (r_state != StIdle) && (r_presc == DivLast);
    assign w_on_done  = w_strobe && (r_phase == OnLast);
    assign w_off_done = w_strobe && (r_phase == OffLast);
    assign w_full     = &r_pending;

    // Next state and dequeue decision
    always_comb begin
        w_state_d = r_state;
        w_deq     = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (r_pending != '0) begin
                    w_state_d = StOn;
                    w_deq     = 1'b1;
                end
            end
            StOn: begin
                if (w_on_done) begin
                    w_state_d = StOff;
                end
            end
            StOff: begin
                if (w_off_done) begin
                    if (r_pending != '0) begin
                        w_state_d = StOn;
                        w_deq     = 1'b1;
                    end else begin
                        w_state_d = StIdle;
                    end
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    assign w_trans = (w_state_d != r_state);

    // Prescaler and phase restart on every state change and rest at 0 in IDLE
    always_comb begin
        w_presc_d = r_presc;
        w_phase_d = r_phase;
        if (w_trans || (w_state_d == StIdle)) begin
            w_presc_d = '0;
            w_phase_d = '0;
        end else if (w_strobe) begin
            w_presc_d = '0;
            w_phase_d = r_phase + 16'd1;
        end else begin
            w_presc_d = r_presc + 32'd1;
        end
    end

    always_comb begin
        w_pending_d = r_pending;
        unique case ({io_blk.tick, w_deq})
            2'b10:   w_pending_d = w_full ? r_pending : r_pending + CNT_W'(1);
            2'b01:   w_pending_d = r_pending - CNT_W'(1);
            default: w_pending_d = r_pending;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= StIdle;
            r_presc   <= '0;
            r_phase   <= '0;
            r_pending <= '0;
        end else begin
            r_state   <= w_state_d;
            r_presc   <= w_presc_d;
            r_phase   <= w_phase_d;
            r_pending <= w_pending_d;
        end
    end

`ifdef TICK_BLINKER_OVF_EN
    logic r_ovf;
    logic w_drop;

    assign w_drop = io_blk.tick && !w_deq && w_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end
    end

    assign io_blk.ovf = r_ovf;
`else
    assign io_blk.ovf = 1'b0;
`endif

    assign io_blk.led     = (r_state == StOn);
    assign io_blk.busy    = (r_state != StIdle) || (r_pending != '0);
    assign io_blk.pending = r_pending;

endmodule

// File: tb/tb_tick_blinker.sv
// Scoreboard bench for tick_blinker (DIV=4, ON_TICKS=2, OFF_TICKS=3, CNT_W=2).
module tb_tick_blinker;

    localparam int unsigned DIV   = 4;
    localparam int unsigned ON_T  = 2;
    localparam int unsigned OFF_T = 3;
    localparam int unsigned CW    = 2;
`ifdef TICK_BLINKER_OVF_EN
    localparam logic OvfEn = 1'b1;
`else
    localparam logic OvfEn = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    tick_blinker_if #(.CNT_W(CW)) bus ();

    tick_blinker #(
        .DIV      (DIV),
        .ON_TICKS (ON_T),
        .OFF_TICKS(OFF_T),
        .CNT_W    (CW)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .io_blk(bus)
    );

    always #5 clk = ~clk;

    // cyc == number of rising edges so far
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic        led;
        logic        busy;
        logic [CW-1:0] pend;
        logic        ovf;
        string       name;
    } exp_t;

    exp_t sb[$];

    task automatic exp_at(input int c, input logic led, input logic busy, input int pend,
                          input logic ovf, input string name);
        exp_t e;
        e.cyc  = c;
        e.led  = led;
        e.busy = busy;
        e.pend = CW'(pend);
        e.ovf  = ovf & OvfEn;
        e.name = name;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            n_checks++;
            if (e.cyc < cyc) begin
                n_errors++;
                $display("FAIL %s: sample for edge %0d missed (now %0d)", e.name, e.cyc, cyc);
            end else if ({bus.led, bus.busy, bus.pending, bus.ovf} !==
                         {e.led, e.busy, e.pend, e.ovf}) begin
                n_errors++;
                $display("FAIL %s @%0d: got led=%b busy=%b pending=%0d ovf=%b, want led=%b busy=%b pending=%0d ovf=%b",
                         e.name, cyc, bus.led, bus.busy, bus.pending, bus.ovf,
                         e.led, e.busy, e.pend, e.ovf);
            end
        end
    end

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Hold tick high so that it is sampled on edges e..e+n-1
    task automatic drive_tick(input int e, input int n);
        wait_cyc(e - 1);
        bus.tick = 1'b1;
        repeat (n) @(negedge clk);
        bus.tick = 1'b0;
    endtask

    initial begin : stim
        int k;
        bus.tick = 1'b0;
        rst      = 1'b1;
        exp_at(1, 0, 0, 0, 0, "reset_a");
        exp_at(2, 0, 0, 0, 0, "reset_b");
        wait_cyc(3);
        rst = 1'b0;

        // Single tick
        k = cyc + 2;
        exp_at(k,      0, 1, 1, 0, "s1_enq");
        exp_at(k + 1,  1, 1, 0, 0, "s1_on_first");
        exp_at(k + 8,  1, 1, 0, 0, "s1_on_last");
        exp_at(k + 9,  0, 1, 0, 0, "s1_off_first");
        exp_at(k + 20, 0, 1, 0, 0, "s1_off_last");
        exp_at(k + 21, 0, 0, 0, 0, "s1_idle");
        drive_tick(k, 1);
        wait_cyc(k + 24);

        // Three consecutive ticks
        k = cyc + 2;
        exp_at(k,      0, 1, 1, 0, "s2_enq");
        exp_at(k + 1,  1, 1, 1, 0, "s2_deq_enq");
        exp_at(k + 2,  1, 1, 2, 0, "s2_pend2");
        exp_at(k + 8,  1, 1, 2, 0, "s2_b1_on_last");
        exp_at(k + 9,  0, 1, 2, 0, "s2_b1_off");
        exp_at(k + 20, 0, 1, 2, 0, "s2_b1_off_last");
        exp_at(k + 21, 1, 1, 1, 0, "s2_b2_rise");
        exp_at(k + 28, 1, 1, 1, 0, "s2_b2_on_last");
        exp_at(k + 29, 0, 1, 1, 0, "s2_b2_off");
        exp_at(k + 40, 0, 1, 1, 0, "s2_b2_off_last");
        exp_at(k + 41, 1, 1, 0, 0, "s2_b3_rise");
        exp_at(k + 49, 0, 1, 0, 0, "s2_b3_off");
        exp_at(k + 60, 0, 1, 0, 0, "s2_b3_off_last");
        exp_at(k + 61, 0, 0, 0, 0, "s2_idle");
        drive_tick(k, 3);
        wait_cyc(k + 64);

        // Tick held two cycles
        k = cyc + 2;
        exp_at(k,      0, 1, 1, 0, "s6_enq");
        exp_at(k + 1,  1, 1, 1, 0, "s6_second");
        exp_at(k + 2,  1, 1, 1, 0, "s6_hold");
        exp_at(k + 21, 1, 1, 0, 0, "s6_b2_rise");
        exp_at(k + 40, 0, 1, 0, 0, "s6_b2_off_last");
        exp_at(k + 41, 0, 0, 0, 0, "s6_idle");
        drive_tick(k, 2);
        wait_cyc(k + 44);

        // Tick coinciding with the OFF->ON dequeue
        k = cyc + 2;
        exp_at(k + 1,  1, 1, 0, 0, "s4_on");
        exp_at(k + 3,  1, 1, 1, 0, "s4_queued");
        exp_at(k + 20, 0, 1, 1, 0, "s4_off_last");
        exp_at(k + 21, 1, 1, 1, 0, "s4_deq_enq");
        exp_at(k + 40, 0, 1, 1, 0, "s4_b2_off_last");
        exp_at(k + 41, 1, 1, 0, 0, "s4_b3_rise");
        exp_at(k + 60, 0, 1, 0, 0, "s4_b3_off_last");
        exp_at(k + 61, 0, 0, 0, 0, "s4_idle");
        drive_tick(k, 1);
        drive_tick(k + 3, 1);
        drive_tick(k + 21, 1);
        wait_cyc(k + 64);

        // Five consecutive ticks: saturation and overflow
        k = cyc + 2;
        exp_at(k,       0, 1, 1, 0, "s3_p1");
        exp_at(k + 1,   1, 1, 1, 0, "s3_p1b");
        exp_at(k + 2,   1, 1, 2, 0, "s3_p2");
        exp_at(k + 3,   1, 1, 3, 0, "s3_p3");
        exp_at(k + 4,   1, 1, 3, 1, "s3_drop");
        exp_at(k + 21,  1, 1, 2, 1, "s3_b2_rise");
        exp_at(k + 41,  1, 1, 1, 1, "s3_b3_rise");
        exp_at(k + 61,  1, 1, 0, 1, "s3_b4_rise");
        exp_at(k + 80,  0, 1, 0, 1, "s3_b4_off_last");
        exp_at(k + 81,  0, 0, 0, 1, "s3_idle");
        exp_at(k + 101, 0, 0, 0, 1, "s3_no_fifth");
        drive_tick(k, 5);
        wait_cyc(k + 104);

        // Asynchronous reset three cycles into ON with two blinks queued
        k = cyc + 2;
        exp_at(k + 3,  1, 1, 2, 1, "s5_before_rst");
        exp_at(k + 4,  0, 0, 0, 0, "s5_async_rst");
        exp_at(k + 5,  0, 0, 0, 0, "s5_rst_held");
        exp_at(k + 10, 0, 0, 0, 0, "s5_after_rst");
        exp_at(k + 30, 0, 0, 0, 0, "s5_quiet");
        drive_tick(k, 3);
        wait_cyc(k + 3);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        wait_cyc(k + 32);

        for (int i = 0; i < 50 && sb.size() > 0; i++) @(negedge clk);
        while (sb.size() > 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: never sampled, expected at edge %0d", sb[0].name, sb[0].cyc);
            void'(sb.pop_front());
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
